// File: rtl/multi_delay_timer.sv
// multi_delay_timer: CHANNELS independent programmable delay timers that share
// one free-running prescaler. Each channel runs a small IDLE/COUNT/DONE FSM.
//
// Request semantics: start, cancel and periodic are level-sampled on every
// rising CLK_100MHz edge. There is no ready/acknowledge, so a request is
// accepted on the cycle it is seen. Per channel, cancel wins over start,
// start wins over normal progression, and Reset wins over everything. done[i]
// is a one-cycle pulse decoded from the registered state, so it never has a
// combinational path from the inputs.
module multi_delay_timer #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 20,
   parameter int PRESCALE = 1
) (
   input  logic                      CLK_100MHz,
   input  logic                      Reset,
   input  logic [CHANNELS-1:0]       start,
   input  logic [CHANNELS-1:0]       cancel,
   input  logic [CHANNELS-1:0]       periodic,
   input  logic [CHANNELS*WIDTH-1:0] period,
   output logic [CHANNELS-1:0]       busy,
   output logic [CHANNELS-1:0]       done,
   output logic                      done_any
);

   // The prescaler counter is at least 1 bit wide. With PRESCALE=1 it stays
   // at 0, so tick is asserted on every cycle.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   logic [PW-1:0] pre_cnt;
   logic          tick;

   assign tick = (pre_cnt == PW'(PRESCALE - 1));

   // Free-running shared prescaler that wraps at PRESCALE-1. A start request
   // does not restart it.
   always_ff @(posedge CLK_100MHz) begin
      if (Reset) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PW'(1);
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      state_t           state;
      logic [WIDTH-1:0] remaining;
      logic             mode;
      logic [WIDTH-1:0] period_i;

      assign period_i = period[g*WIDTH +: WIDTH];

      // Per-channel FSM. The counter stops at 1, so it never wraps, and a
      // loaded period of 0 expires on the first tick just like a period of 1.
      always_ff @(posedge CLK_100MHz) begin
         if (Reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            mode      <= 1'b0;
         end else if (cancel[g]) begin
            state     <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start[g]) begin
                     state     <= S_COUNT;
                     remaining <= period_i;
                     mode      <= periodic[g];
                  end
               end
               S_COUNT: begin
                  if (start[g]) begin
                     remaining <= period_i;
                     mode      <= periodic[g];
                  end else if (tick) begin
                     if (remaining <= WIDTH'(1)) begin
                        state <= S_DONE;
                     end else begin
                        remaining <= remaining - WIDTH'(1);
                     end
                  end
               end
               S_DONE: begin
                  if (start[g]) begin
                     state     <= S_COUNT;
                     remaining <= period_i;
                     mode      <= periodic[g];
                  end else if (mode) begin
                     state     <= S_COUNT;
                     remaining <= period_i;
                  end else begin
                     state     <= S_IDLE;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end

      assign busy[g] = (state == S_COUNT);
      assign done[g] = (state == S_DONE);
   end

   assign done_any = |done;

endmodule

// File: tb/tb_multi_delay_timer.sv
// Directed bench for multi_delay_timer. The main instance uses the default
// parameters. A PRESCALE=4 instance covers the tick alignment case. A
// WIDTH=12 instance covers the full-scale period, because a 2^20-cycle run
// does not fit the simulation budget.
module tb_multi_delay_timer;

   localparam int CH  = 4;
   localparam int W   = 20;
   localparam int WS  = 12;

   logic clk = 1'b0;
   logic Reset;

   logic [CH-1:0]   a_start, a_cancel, a_periodic, a_busy, a_done;
   logic [CH*W-1:0] a_period;
   logic            a_done_any;

   logic [CH-1:0]   p_start, p_cancel, p_periodic, p_busy, p_done;
   logic [CH*W-1:0] p_period;
   logic            p_done_any;

   logic [CH-1:0]    w_start, w_cancel, w_periodic, w_busy, w_done;
   logic [CH*WS-1:0] w_period;
   logic             w_done_any;

   int n_cmp  = 0;
   int n_fail = 0;

   // 100 MHz clock
   always #5 clk = ~clk;

   multi_delay_timer #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(1)) dut_a (
      .CLK_100MHz(clk), .Reset(Reset), .start(a_start), .cancel(a_cancel),
      .periodic(a_periodic), .period(a_period), .busy(a_busy), .done(a_done),
      .done_any(a_done_any));

   multi_delay_timer #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(4)) dut_p (
      .CLK_100MHz(clk), .Reset(Reset), .start(p_start), .cancel(p_cancel),
      .periodic(p_periodic), .period(p_period), .busy(p_busy), .done(p_done),
      .done_any(p_done_any));

   multi_delay_timer #(.CHANNELS(CH), .WIDTH(WS), .PRESCALE(1)) dut_w (
      .CLK_100MHz(clk), .Reset(Reset), .start(w_start), .cancel(w_cancel),
      .periodic(w_periodic), .period(w_period), .busy(w_busy), .done(w_done),
      .done_any(w_done_any));

   // One clock step. Inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      a_start = '0; a_cancel = '0; a_periodic = '0; a_period = '0;
      p_start = '0; p_cancel = '0; p_periodic = '0; p_period = '0;
      w_start = '0; w_cancel = '0; w_periodic = '0; w_period = '0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      n_cmp++;
      if (a_busy !== 4'b0000) begin
         n_fail++; $display("FAIL reset_a_busy got=%b exp=0000", a_busy);
      end
      n_cmp++;
      if (a_done !== 4'b0000 || a_done_any !== 1'b0) begin
         n_fail++; $display("FAIL reset_a_done got=%b/%b exp=0000/0", a_done, a_done_any);
      end
      n_cmp++;
      if (p_busy !== 4'b0000 || p_done !== 4'b0000 || w_busy !== 4'b0000 || w_done !== 4'b0000) begin
         n_fail++; $display("FAIL reset_pw got p=%b/%b w=%b/%b exp=0", p_busy, p_done, w_busy, w_done);
      end
   endtask

   // Channel 0, one-shot, N=5, start pulsed in cycle 0
   task automatic test_one_shot(input string tag);
      a_period[0 +: W] = 20'd5;
      a_periodic[0] = 1'b0;
      a_start[0] = 1'b1;
      step();
      a_start[0] = 1'b0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         n_cmp++;
         if (a_busy[0] !== (cyc <= 5)) begin
            n_fail++; $display("FAIL %s_busy cyc=%0d got=%b exp=%b", tag, cyc, a_busy[0], (cyc <= 5));
         end
         n_cmp++;
         if (a_done[0] !== (cyc == 6) || a_done_any !== (cyc == 6)) begin
            n_fail++; $display("FAIL %s_done cyc=%0d got=%b/%b exp=%b", tag, cyc, a_done[0], a_done_any, (cyc == 6));
         end
         step();
      end
   endtask

   // Channel 1, periodic, N=3, cancel in cycle 9
   task automatic test_periodic();
      logic exp_d, exp_b;
      a_period[1*W +: W] = 20'd3;
      a_periodic[1] = 1'b1;
      a_start[1] = 1'b1;
      step();
      a_start[1] = 1'b0;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         exp_d = (cyc == 4) || (cyc == 8);
         exp_b = (cyc <= 9) && !exp_d;
         n_cmp++;
         if (a_done[1] !== exp_d || a_busy[1] !== exp_b) begin
            n_fail++; $display("FAIL periodic cyc=%0d got done=%b busy=%b exp done=%b busy=%b", cyc, a_done[1], a_busy[1], exp_d, exp_b);
         end
         a_cancel[1] = (cyc == 9);
         step();
      end
      a_cancel[1] = 1'b0;
      a_periodic[1] = 1'b0;
   endtask

   // Channel 2, N=10, retrigger in cycle 6, then cancel beats start in IDLE
   task automatic test_retrigger();
      a_period[2*W +: W] = 20'd10;
      a_start[2] = 1'b1;
      step();
      a_start[2] = 1'b0;
      for (int cyc = 1; cyc <= 19; cyc++) begin
         n_cmp++;
         if (a_done[2] !== (cyc == 17) || a_busy[2] !== (cyc <= 16)) begin
            n_fail++; $display("FAIL retrigger cyc=%0d got done=%b busy=%b exp done=%b busy=%b", cyc, a_done[2], a_busy[2], (cyc == 17), (cyc <= 16));
         end
         a_start[2] = (cyc == 6);
         step();
      end
      a_start[2] = 1'b1;
      a_cancel[2] = 1'b1;
      step();
      a_start[2] = 1'b0;
      a_cancel[2] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (a_busy[2] !== 1'b0 || a_done[2] !== 1'b0) begin
            n_fail++; $display("FAIL cancel_beats_start k=%0d got busy=%b done=%b exp 0/0", k, a_busy[2], a_done[2]);
         end
         step();
      end
   endtask

   // Channel 0, N=0 behaves as N=1
   task automatic test_zero_period();
      a_period[0 +: W] = 20'd0;
      a_start[0] = 1'b1;
      step();
      a_start[0] = 1'b0;
      for (int cyc = 1; cyc <= 3; cyc++) begin
         n_cmp++;
         if (a_busy[0] !== (cyc == 1) || a_done[0] !== (cyc == 2)) begin
            n_fail++; $display("FAIL zero_period cyc=%0d got busy=%b done=%b exp busy=%b done=%b", cyc, a_busy[0], a_done[0], (cyc == 1), (cyc == 2));
         end
         step();
      end
   endtask

   // All channels N=3 started together expire together
   task automatic test_all_channels();
      logic [CH-1:0] exp_d, exp_b;
      for (int c = 0; c < CH; c++) a_period[c*W +: W] = 20'd3;
      a_start = 4'b1111;
      step();
      a_start = 4'b0000;
      for (int cyc = 1; cyc <= 5; cyc++) begin
         exp_d = (cyc == 4) ? 4'b1111 : 4'b0000;
         exp_b = (cyc <= 3) ? 4'b1111 : 4'b0000;
         n_cmp++;
         if (a_done !== exp_d || a_busy !== exp_b || a_done_any !== (cyc == 4)) begin
            n_fail++; $display("FAIL all_channels cyc=%0d got done=%b busy=%b any=%b exp done=%b busy=%b", cyc, a_done, a_busy, a_done_any, exp_d, exp_b);
         end
         step();
      end
   endtask

   // Channel 3, N=4, period rewritten to 9 mid-count has no effect
   task automatic test_period_change();
      a_period[3*W +: W] = 20'd4;
      a_start[3] = 1'b1;
      step();
      a_start[3] = 1'b0;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         n_cmp++;
         if (a_done[3] !== (cyc == 5) || a_busy[3] !== (cyc <= 4)) begin
            n_fail++; $display("FAIL period_change cyc=%0d got done=%b busy=%b exp done=%b busy=%b", cyc, a_done[3], a_busy[3], (cyc == 5), (cyc <= 4));
         end
         if (cyc == 2) a_period[3*W +: W] = 20'd9;
         step();
      end
   endtask

   // WIDTH=12 instance, full-scale period 4095, done 4096 cycles after start
   task automatic test_max_period();
      logic early;
      early = 1'b0;
      w_period[0 +: WS] = 12'hFFF;
      w_start[0] = 1'b1;
      step();
      w_start[0] = 1'b0;
      for (int cyc = 1; cyc < 4095; cyc++) begin
         early = early | w_done[0] | ~w_busy[0];
         step();
      end
      n_cmp++;
      if (early !== 1'b0) begin
         n_fail++; $display("FAIL max_period_early got=%b exp=0", early);
      end
      n_cmp++;
      if (w_busy[0] !== 1'b1 || w_done[0] !== 1'b0) begin
         n_fail++; $display("FAIL max_period_c4095 got busy=%b done=%b exp 1/0", w_busy[0], w_done[0]);
      end
      step();
      n_cmp++;
      if (w_done[0] !== 1'b1 || w_done_any !== 1'b1) begin
         n_fail++; $display("FAIL max_period_c4096 got done=%b any=%b exp 1/1", w_done[0], w_done_any);
      end
      step();
      n_cmp++;
      if (w_done[0] !== 1'b0 || w_busy[0] !== 1'b0) begin
         n_fail++; $display("FAIL max_period_c4097 got done=%b busy=%b exp 0/0", w_done[0], w_busy[0]);
      end
   endtask

   // PRESCALE=4, N=2, start while the prescaler is 0: ticks fall in cycles
   // 3 and 7, so done lands in cycle 8
   task automatic test_prescale();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      p_period[0 +: W] = 20'd2;
      p_start[0] = 1'b1;
      step();
      p_start[0] = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         n_cmp++;
         if (p_done[0] !== (cyc == 8) || p_busy[0] !== (cyc <= 7)) begin
            n_fail++; $display("FAIL prescale cyc=%0d got done=%b busy=%b exp done=%b busy=%b", cyc, p_done[0], p_busy[0], (cyc == 8), (cyc <= 7));
         end
         step();
      end
   endtask

   // Reset while channels 0 and 3 count aborts both with no done pulse
   task automatic test_reset_mid_count();
      logic seen;
      seen = 1'b0;
      a_period[0 +: W]   = 20'd5;
      a_period[3*W +: W] = 20'd7;
      a_start = 4'b1001;
      step();
      a_start = 4'b0000;
      step();
      n_cmp++;
      if (a_busy !== 4'b1001) begin
         n_fail++; $display("FAIL pre_reset_busy got=%b exp=1001", a_busy);
      end
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      n_cmp++;
      if (a_busy !== 4'b0000 || a_done !== 4'b0000 || a_done_any !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset got busy=%b done=%b any=%b exp 0000/0000/0", a_busy, a_done, a_done_any);
      end
      for (int k = 0; k < 10; k++) begin
         seen = seen | a_done_any | (|a_busy);
         step();
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_quiet got=%b exp=0", seen);
      end
      test_one_shot("after_reset");
   endtask

   initial begin
      Reset = 1'b1;
      clear_inputs();
      test_reset();
      test_one_shot("one_shot");
      test_periodic();
      test_retrigger();
      test_zero_period();
      test_all_channels();
      test_period_change();
      test_max_period();
      test_prescale();
      test_reset_mid_count();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
